register_file_sb: RTL and testbench

Parametrised successor to the 8x16 processor register file.
- Generalised data width and register count.
- Write-to-read bypass on both read ports.
- Per-register busy scoreboard so the decoder can detect pending writebacks (RAW hazards).
- Storage is cleared by a post-reset sweep, one entry per cycle, so the array maps onto RAM-style storage.
- Sits between decode (read/issue) and writeback.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/register_file_sb_if.sv | 34 +++
 rtl/regfile_scoreboard.sv | 43 ++++
 rtl/register_file_sb.sv | 112 +++++++++++
 tb/tb_register_file_sb.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with busy scoreboard.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   state_t                 : clear-sweep / run state
//   addr_t                  : register address at the default width
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 3;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/writeback bus of the register file.
//   master : decoder/writeback side (drives write, issue and read addresses)
//   slave  : register file (drives ready, read data and busy flags)
interface register_file_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  logic              ready;
  logic              write;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              issue;
  logic [ADDR_W-1:0] issueAddr;
  logic [ADDR_W-1:0] rdAddrA;
  logic [DATA_W-1:0] rdDataA;
  logic              rdBusyA;
  logic [ADDR_W-1:0] rdAddrB;
  logic [DATA_W-1:0] rdDataB;
  logic              rdBusyB;

  modport master (
    input  ready, rdDataA, rdBusyA, rdDataB, rdBusyB,
    output write, wrAddr, wrData, issue, issueAddr, rdAddrA, rdAddrB
  );

  modport slave (
    output ready, rdDataA, rdBusyA, rdDataB, rdBusyB,
    input  write, wrAddr, wrData, issue, issueAddr, rdAddrA, rdAddrB
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback (issue wins on
// a same-address collision). Busy reads are bypassed so a register being
// written back this cycle is reported free.
//   clk, reset          : clock, synchronous active-high reset (clears all bits)
//   write, wrAddr       : qualified writeback
//   issue, issueAddr    : qualified issue
//   rdAddrA/B           : read addresses
//   busyA_c / busyB_c   : combinational busy flags
module regfile_scoreboard #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issueAddr,
  input  logic [ADDR_W-1:0] rdAddrA,
  input  logic [ADDR_W-1:0] rdAddrB,
  output logic              busyA_c,
  output logic              busyB_c
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;

  logic [NUM_REGS-1:0] busy;

  // Issue is applied after writeback so it wins on the same address.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      if (write) busy[wrAddr]    <= 1'b0;
      if (issue) busy[issueAddr] <= 1'b1;
    end
  end

  always_comb begin
    busyA_c = busy[rdAddrA] & ~(write && (wrAddr == rdAddrA));
    busyB_c = busy[rdAddrB] & ~(write && (wrAddr == rdAddrB));
  end

endmodule

// File: rtl/register_file_sb.sv
// Parametrised register file with write-to-read bypass and busy scoreboard.
// After reset the array is cleared by a sweep, one entry per cycle, so the
// storage has a single write port and no reset (RAM-friendly).
//   clk, reset : clock, synchronous active-high reset (restarts the sweep)
//   bus        : decode/writeback interface (slave side)
// Build option: REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input logic                clk,
  input logic                reset,
  register_file_sb_if.slave  bus
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
  localparam logic ZERO_REG = 1'b1;
`else
  localparam logic ZERO_REG = 1'b0;
`endif

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              readyQ;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              writeEn;
  logic              issueEn;
  logic              busyA;
  logic              busyB;

  // Sweep FSM: CLEAR walks ptr over every entry, then RUN until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= CLEAR;
      ptr    <= '0;
      readyQ <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ADDR_W'(ptr + 1'b1);
          if (ptr == ADDR_W'(NUM_REGS - 1)) begin
            state  <= RUN;
            readyQ <= 1'b1;
          end
        end
        RUN: begin
          state  <= RUN;
          readyQ <= 1'b1;
        end
        default: begin
          state  <= CLEAR;
          ptr    <= '0;
          readyQ <= 1'b0;
        end
      endcase
    end
  end

  // Writes and issues only count in RUN; register 0 is immune when hardwired.
  always_comb begin
    writeEn = readyQ && bus.write && !(ZERO_REG && (bus.wrAddr == '0));
    issueEn = readyQ && bus.issue && !(ZERO_REG && (bus.issueAddr == '0));
  end

  // Single write port: sweep clear in CLEAR, writeback in RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        regs[ptr] <= '0;
      end else if (writeEn) begin
        regs[bus.wrAddr] <= bus.wrData;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .write     (writeEn),
    .wrAddr    (bus.wrAddr),
    .issue     (issueEn),
    .issueAddr (bus.issueAddr),
    .rdAddrA   (bus.rdAddrA),
    .rdAddrB   (bus.rdAddrB),
    .busyA_c   (busyA),
    .busyB_c   (busyB)
  );

  // Bypassed read muxes; everything reads as zero until the sweep is done.
  always_comb begin
    bus.rdDataA = '0;
    bus.rdDataB = '0;
    if (readyQ && !(ZERO_REG && (bus.rdAddrA == '0))) begin
      bus.rdDataA = (writeEn && (bus.wrAddr == bus.rdAddrA)) ? bus.wrData
                                                            : regs[bus.rdAddrA];
    end
    if (readyQ && !(ZERO_REG && (bus.rdAddrB == '0))) begin
      bus.rdDataB = (writeEn && (bus.wrAddr == bus.rdAddrB)) ? bus.wrData
                                                            : regs[bus.rdAddrB];
    end
    bus.rdBusyA = readyQ && busyA;
    bus.rdBusyB = readyQ && busyB;
    bus.ready   = readyQ;
  end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb with a behavioural reference model.
module tb_register_file_sb;
  import regfile_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int NREG = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  register_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  register_file_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  // Reference model: contents as seen after the sweep, busy flags, and the
  // number of reset-free edges since the last reset.
  logic [DW-1:0] mRegs [NREG];
  bit            mBusy [NREG];
  int            mSince = 0;

  function automatic bit mReady();
    return mSince >= NREG;
  endfunction

  function automatic bit isZero(input addr_t a);
    return ZR && (a == 3'd0);
  endfunction

  function automatic logic [DW-1:0] expData(input addr_t a);
    if (!mReady() || isZero(a)) return '0;
    if (bus.write && !isZero(bus.wrAddr) && bus.wrAddr == a) return bus.wrData;
    return mRegs[a];
  endfunction

  function automatic bit expBusy(input addr_t a);
    if (!mReady() || isZero(a)) return 1'b0;
    if (bus.write && !isZero(bus.wrAddr) && bus.wrAddr == a) return 1'b0;
    return mBusy[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mSince = 0;
      for (int i = 0; i < NREG; i++) begin
        mRegs[i] = '0;
        mBusy[i] = 1'b0;
      end
    end else if (!mReady()) begin
      mSince = mSince + 1;
    end else begin
      if (bus.write && !isZero(bus.wrAddr)) begin
        mRegs[bus.wrAddr] = bus.wrData;
        mBusy[bus.wrAddr] = 1'b0;
      end
      if (bus.issue && !isZero(bus.issueAddr)) mBusy[bus.issueAddr] = 1'b1;
    end
  end

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      cmp("model.ready",   DW'(bus.ready),   DW'(mReady()));
      cmp("model.rdDataA", bus.rdDataA,      expData(bus.rdAddrA));
      cmp("model.rdDataB", bus.rdDataB,      expData(bus.rdAddrB));
      cmp("model.rdBusyA", DW'(bus.rdBusyA), DW'(expBusy(bus.rdAddrA)));
      cmp("model.rdBusyB", DW'(bus.rdBusyB), DW'(expBusy(bus.rdAddrB)));
    end
  end

  // Advance one edge; inputs change 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.write = 1'b0;
    bus.issue = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.write = 1'b0; bus.wrAddr = '0; bus.wrData = '0;
    bus.issue = 1'b0; bus.issueAddr = '0;
    bus.rdAddrA = '0; bus.rdAddrB = '0;
    reset = 1'b1;
    step(); step();
    checkEn = 1'b1;
    settle();
    cmp("reset.ready", DW'(bus.ready), 16'd0);
    cmp("reset.rdDataA", bus.rdDataA, 16'h0000);

    // Sweep after reset: ready is high from the 8th edge on.
    reset = 1'b0;
    for (int k = 1; k <= NREG; k++) begin
      step();
      settle();
      cmp($sformatf("sweep1.ready%0d", k), DW'(bus.ready), DW'(k == NREG));
    end

    // Pre-load every register with 0xFFFF.
    for (int i = 0; i < NREG; i++) begin
      bus.write = 1'b1; bus.wrAddr = addr_t'(i); bus.wrData = 16'hFFFF;
      step();
    end
    idle();
    bus.rdAddrA = 3'd5; bus.rdAddrB = 3'd7;
    settle();
    cmp("preload.r5", bus.rdDataA, 16'hFFFF);
    cmp("preload.r7", bus.rdDataB, 16'hFFFF);

    // Reset, then a second reset on the 4th sweep edge; a write during CLEAR is dropped.
    reset = 1'b1; step();
    reset = 1'b0;
    bus.write = 1'b1; bus.wrAddr = 3'd5; bus.wrData = 16'h1234;
    step(); step(); step();
    reset = 1'b1; step();
    reset = 1'b0;
    for (int k = 1; k <= NREG; k++) begin
      step();
      if (k == 1) idle();
      settle();
      cmp($sformatf("sweep2.ready%0d", k), DW'(bus.ready), DW'(k == NREG));
    end
    idle();
    for (int i = 0; i < NREG; i++) begin
      bus.rdAddrA = addr_t'(i); bus.rdAddrB = addr_t'(NREG - 1 - i);
      #2;
      cmp($sformatf("cleared.r%0d", i), bus.rdDataA, 16'h0000);
      cmp($sformatf("clearedBusy.r%0d", i), DW'(bus.rdBusyA), 16'd0);
    end

    // Bypass on both ports.
    step();
    bus.write = 1'b1; bus.wrAddr = 3'd3; bus.wrData = 16'hBEEF;
    bus.rdAddrA = 3'd3; bus.rdAddrB = 3'd3;
    settle();
    cmp("bypass.A", bus.rdDataA, 16'hBEEF);
    cmp("bypass.B", bus.rdDataB, 16'hBEEF);
    step(); idle();
    settle();
    cmp("held.r3", bus.rdDataA, 16'hBEEF);

    // Scoreboard: issue r2, then write it back.
    bus.issue = 1'b1; bus.issueAddr = 3'd2; bus.rdAddrA = 3'd2;
    step(); idle();
    settle();
    cmp("issue.busyA", DW'(bus.rdBusyA), 16'd1);
    bus.write = 1'b1; bus.wrAddr = 3'd2; bus.wrData = 16'h00AA;
    settle();
    cmp("wbCycle.busyA", DW'(bus.rdBusyA), 16'd0);
    cmp("wbCycle.dataA", bus.rdDataA, 16'h00AA);
    step(); idle();
    settle();
    cmp("afterWb.busyA", DW'(bus.rdBusyA), 16'd0);
    cmp("afterWb.dataA", bus.rdDataA, 16'h00AA);

    // Same-edge write and issue: data lands, issue wins busy.
    bus.write = 1'b1; bus.wrAddr = 3'd6; bus.wrData = 16'h5555;
    bus.issue = 1'b1; bus.issueAddr = 3'd6; bus.rdAddrB = 3'd6;
    step(); idle();
    settle();
    cmp("wi.dataB", bus.rdDataB, 16'h5555);
    cmp("wi.busyB", DW'(bus.rdBusyB), 16'd1);
    bus.issue = 1'b1; bus.issueAddr = 3'd6;
    step(); idle();
    settle();
    cmp("waw.busyB", DW'(bus.rdBusyB), 16'd1);
    bus.write = 1'b1; bus.wrAddr = 3'd6; bus.wrData = 16'h6666;
    step(); idle();
    settle();
    cmp("clr.busyB", DW'(bus.rdBusyB), 16'd0);
    cmp("clr.dataB", bus.rdDataB, 16'h6666);

    // Register 0: hardwired zero when enabled, ordinary otherwise.
    bus.write = 1'b1; bus.wrAddr = 3'd0; bus.wrData = 16'hFFFF;
    bus.issue = 1'b1; bus.issueAddr = 3'd0; bus.rdAddrA = 3'd0;
    settle();
    cmp("r0.wrCycleData", bus.rdDataA, ZR ? 16'h0000 : 16'hFFFF);
    cmp("r0.wrCycleBusy", DW'(bus.rdBusyA), 16'd0);
    step(); idle();
    settle();
    cmp("r0.data", bus.rdDataA, ZR ? 16'h0000 : 16'hFFFF);
    cmp("r0.busy", DW'(bus.rdBusyA), ZR ? 16'd0 : 16'd1);

    // Independent write and issue to different addresses.
    bus.write = 1'b1; bus.wrAddr = 3'd1; bus.wrData = 16'hA5A5;
    bus.issue = 1'b1; bus.issueAddr = 3'd4;
    bus.rdAddrA = 3'd1; bus.rdAddrB = 3'd4;
    step(); idle();
    settle();
    cmp("indep.dataA", bus.rdDataA, 16'hA5A5);
    cmp("indep.busyA", DW'(bus.rdBusyA), 16'd0);
    cmp("indep.busyB", DW'(bus.rdBusyB), 16'd1);

    step();
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
